// File: rtl/rf_writeback.sv
// rf_writeback: register-file write port producer merging ALU results and queued load responses
module rf_writeback #(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [4:0]                alu_rd,
    input  logic [31:0]               alu_data,
    input  logic                      ld_issue,
    input  logic [4:0]                ld_issue_rd,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [4:0]                ld_rd,
    input  logic [31:0]               ld_data,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    output logic                      hazard,
    output logic                      rf_wen,
    output logic [4:0]                rf_rd,
    output logic [31:0]               rf_wdata,
    output logic [$clog2(LQ_DEPTH):0] lq_count
);
    localparam int AW = $clog2(LQ_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [36:0]   mem_q [LQ_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          rf_wen_q, rf_wen_d, src_ld_q, src_ld_d;
    logic [4:0]    rf_rd_q, rf_rd_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          empty, push, pop, alu_win;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    always_comb begin
        empty     = count_q == '0;
        ld_ready  = count_q != CW'(LQ_DEPTH);
        alu_ready = empty || starve_q != SW'(STARVE_LIMIT);
        alu_win   = alu_valid && alu_ready;
        push      = ld_valid && ld_ready;
        pop       = !alu_win && !empty;
        {head_rd, head_data} = mem_q[rd_ptr_q];
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        // Any cycle the queue is non-empty and does not pop, the ALU took the port.
        starve_d  = (empty || pop) ? '0 : starve_q + 1'b1;
        rf_wen_d  = alu_win ? alu_rd != 5'd0 : pop && head_rd != 5'd0;
        rf_rd_d   = alu_win ? alu_rd : pop ? head_rd : rf_rd_q;
        rf_wdata_d = alu_win ? alu_data : pop ? head_data : rf_wdata_q;
        src_ld_d  = pop;
        pending_d = pending_q;
        if (rf_wen_q && src_ld_q)
            pending_d[rf_rd_q] = 1'b0;
        if (ld_issue && ld_issue_rd != 5'd0)
            pending_d[ld_issue_rd] = 1'b1;
        hazard = (rs1 != 5'd0 && pending_q[rs1]) || (rs2 != 5'd0 && pending_q[rs2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            pending_q  <= '0;
            rf_wen_q   <= 1'b0;
            src_ld_q   <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            pending_q  <= pending_d;
            rf_wen_q   <= rf_wen_d;
            src_ld_q   <= src_ld_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {ld_rd, ld_data};
    end

    assign rf_wen   = rf_wen_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign lq_count = count_q;
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed scenarios plus randomized traffic against a queue-based reference model
module tb_rf_writeback;
    localparam int LQ = 4;
    localparam int SL = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic alu_valid = 1'b0, ld_issue = 1'b0, ld_valid = 1'b0;
    logic [4:0] alu_rd = '0, ld_issue_rd = '0, ld_rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] alu_data = '0, ld_data = '0;
    logic alu_ready, ld_ready, hazard, rf_wen;
    logic [4:0] rf_rd;
    logic [31:0] rf_wdata;
    logic [2:0] lq_count;

    int checks = 0, passed = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    // Reference model: a plain queue of pending responses and the expected write port.
    ent_t lq[$];
    int starve = 0;
    bit [31:0] pend = '0;
    bit m_wen = 0, m_src = 0;
    logic [4:0] m_rd = '0;
    logic [31:0] m_wd = '0;

    rf_writeback #(.LQ_DEPTH(LQ), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .lq_count(lq_count)
    );

    always #5 clk = ~clk;

    function automatic bit m_alu_ready();
        return !(lq.size() != 0 && starve == SL);
    endfunction

    function automatic bit m_ld_ready();
        return lq.size() != LQ;
    endfunction

    function automatic bit m_hazard();
        return (rs1 != 0 && pend[rs1]) || (rs2 != 0 && pend[rs2]);
    endfunction

    task automatic tick();
        bit aw, pop, push;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            lq.delete();
            starve = 0;
            pend = '0;
            m_wen = 0; m_src = 0; m_rd = '0; m_wd = '0;
        end else begin
            aw   = alu_valid && m_alu_ready();
            pop  = !aw && lq.size() != 0;
            push = ld_valid && m_ld_ready();
            starve = (lq.size() == 0 || pop) ? 0 : starve + 1;
            if (m_wen && m_src) pend[m_rd] = 1'b0;
            if (ld_issue && ld_issue_rd != 0) pend[ld_issue_rd] = 1'b1;
            if (aw) begin
                m_wen = alu_rd != 0; m_rd = alu_rd; m_wd = alu_data; m_src = 0;
            end else if (pop) begin
                e = lq.pop_front();
                m_wen = e.rd != 0; m_rd = e.rd; m_wd = e.d; m_src = 1;
            end else begin
                m_wen = 0; m_src = 0;
            end
            if (push) begin
                e.rd = ld_rd; e.d = ld_data;
                lq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (rf_wen !== 1'b0) $display("FAIL reset_wen: got %b want 0", rf_wen); else passed++;
        checks++; if (rf_rd !== 5'd0) $display("FAIL reset_rd: got %0d want 0", rf_rd); else passed++;
        checks++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", rf_wdata); else passed++;
        checks++; if (lq_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", lq_count); else passed++;
        checks++; if (alu_ready !== 1'b1) $display("FAIL reset_alu_ready: got %b want 1", alu_ready); else passed++;
        checks++; if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %b want 1", ld_ready); else passed++;
        checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard: got %b want 0", hazard); else passed++;
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) $display("FAIL alu_ready: got %b want 1", alu_ready); else passed++;
        tick();
        alu_valid = 1'b0;
        checks++; if (rf_wen !== 1'b1) $display("FAIL alu_wen: got %b want 1", rf_wen); else passed++;
        checks++; if (rf_rd !== 5'd5) $display("FAIL alu_rd: got %0d want 5", rf_rd); else passed++;
        checks++; if (rf_wdata !== 32'hDEADBEEF) $display("FAIL alu_wdata: got %h want deadbeef", rf_wdata); else passed++;
        tick();
        checks++; if (rf_wen !== 1'b0) $display("FAIL alu_wen_drop: got %b want 0", rf_wen); else passed++;
        checks++; if (rf_rd !== 5'd5) $display("FAIL alu_rd_hold: got %0d want 5", rf_rd); else passed++;
    endtask

    task automatic test_load_hazard();
        ld_issue = 1'b1; ld_issue_rd = 5'd7; rs1 = 5'd7;
        #1;
        checks++; if (hazard !== 1'b0) $display("FAIL ld_haz_pre: got %b want 0", hazard); else passed++;
        tick();
        ld_issue = 1'b0;
        #1;
        checks++; if (hazard !== 1'b1) $display("FAIL ld_haz_set: got %b want 1", hazard); else passed++;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12345678;
        #1;
        checks++; if (ld_ready !== 1'b1) $display("FAIL ld_ready: got %b want 1", ld_ready); else passed++;
        tick();
        ld_valid = 1'b0;
        #1;
        checks++; if (lq_count !== 3'd1) $display("FAIL ld_count1: got %0d want 1", lq_count); else passed++;
        checks++; if (rf_wen !== 1'b0) $display("FAIL ld_wen_enq: got %b want 0", rf_wen); else passed++;
        tick();
        checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h12345678)
            $display("FAIL ld_write: got wen=%b rd=%0d data=%h want 1/7/12345678", rf_wen, rf_rd, rf_wdata); else passed++;
        checks++; if (hazard !== 1'b1) $display("FAIL ld_haz_hold: got %b want 1", hazard); else passed++;
        checks++; if (lq_count !== 3'd0) $display("FAIL ld_count0: got %0d want 0", lq_count); else passed++;
        tick();
        checks++; if (hazard !== 1'b0) $display("FAIL ld_haz_clear: got %b want 0", hazard); else passed++;
        checks++; if (rf_wen !== 1'b0) $display("FAIL ld_wen_drop: got %b want 0", rf_wen); else passed++;
        rs1 = 5'd0;
    endtask

    task automatic test_starve();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd1;
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hA5A5A5A5;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < SL; i++) begin
            alu_rd = 5'(i + 2); alu_data = 32'(i + 2);
            #1;
            checks++; if (alu_ready !== 1'b1) $display("FAIL starve_ready%0d: got %b want 1", i, alu_ready); else passed++;
            tick();
            checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'(i + 2))
                $display("FAIL starve_alu%0d: got wen=%b rd=%0d want 1/%0d", i, rf_wen, rf_rd, i + 2); else passed++;
        end
        alu_rd = 5'd6; alu_data = 32'd6;
        #1;
        checks++; if (alu_ready !== 1'b0) $display("FAIL starve_block: got %b want 0", alu_ready); else passed++;
        tick();
        checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'hA5A5A5A5)
            $display("FAIL starve_load: got wen=%b rd=%0d data=%h want 1/10/a5a5a5a5", rf_wen, rf_rd, rf_wdata); else passed++;
        checks++; if (alu_ready !== 1'b1) $display("FAIL starve_release: got %b want 1", alu_ready); else passed++;
        tick();
        checks++; if (rf_rd !== 5'd6) $display("FAIL starve_alu_after: got %0d want 6", rf_rd); else passed++;
        alu_valid = 1'b0;
        tick();
    endtask

    task automatic test_fifo_full();
        int k = 0, maxc = 0, cyc = 0;
        bit saw_full = 0, acc;
        logic [31:0] got[$];
        while (cyc < 80 && !(k == 6 && lq_count == 0)) begin
            alu_valid = k < 6; alu_rd = 5'd1; alu_data = 32'(cyc);
            ld_valid = k < 6; ld_rd = 5'(20 + k); ld_data = 32'hA0000000 + 32'(k);
            #1;
            acc = ld_valid && ld_ready;
            if (ld_valid && !ld_ready) saw_full = 1;
            tick();
            if (acc) k++;
            if (int'(lq_count) > maxc) maxc = int'(lq_count);
            if (rf_wen && rf_rd >= 5'd20) got.push_back(rf_wdata);
            cyc++;
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        checks++; if (lq_count !== 3'd0) $display("FAIL full_drain_timeout: got count %0d want 0", lq_count); else passed++;
        checks++; if (maxc != 4) $display("FAIL full_max_count: got %0d want 4", maxc); else passed++;
        checks++; if (!saw_full) $display("FAIL full_ld_ready: got never-low want low-when-full"); else passed++;
        checks++; if (got.size() != 6) $display("FAIL full_writes: got %0d want 6", got.size()); else passed++;
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'hA0000000 + 32'(i))
                $display("FAIL full_order%0d: got %h want %h", i, got[i], 32'hA0000000 + 32'(i)); else passed++;
        end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF0000;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0000EEEE;
        ld_issue = 1'b1; ld_issue_rd = 5'd0; rs1 = 5'd0;
        #1;
        checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1)
            $display("FAIL x0_ready: got alu=%b ld=%b want 1/1", alu_ready, ld_ready); else passed++;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0; ld_issue = 1'b0;
        #1;
        checks++; if (rf_wen !== 1'b0) $display("FAIL x0_alu_wen: got %b want 0", rf_wen); else passed++;
        checks++; if (lq_count !== 3'd1) $display("FAIL x0_count1: got %0d want 1", lq_count); else passed++;
        checks++; if (hazard !== 1'b0) $display("FAIL x0_hazard: got %b want 0", hazard); else passed++;
        tick();
        checks++; if (rf_wen !== 1'b0) $display("FAIL x0_ld_wen: got %b want 0", rf_wen); else passed++;
        checks++; if (lq_count !== 3'd0) $display("FAIL x0_count0: got %0d want 0", lq_count); else passed++;
        tick();
        checks++; if (rf_wen !== 1'b0) $display("FAIL x0_idle_wen: got %b want 0", rf_wen); else passed++;
    endtask

    task automatic test_same_edge_and_reset();
        ld_issue = 1'b1; ld_issue_rd = 5'd9; rs2 = 5'd9;
        tick();
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99999999;
        tick();
        ld_valid = 1'b0;
        tick();
        checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd9)
            $display("FAIL same_write: got wen=%b rd=%0d want 1/9", rf_wen, rf_rd); else passed++;
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick();
        ld_issue = 1'b0;
        #1;
        checks++; if (hazard !== 1'b1) $display("FAIL same_set_wins: got %b want 1", hazard); else passed++;
        tick();
        checks++; if (hazard !== 1'b1) $display("FAIL same_set_hold: got %b want 1", hazard); else passed++;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd3;
        ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'hBB;
        tick();
        tick();
        checks++; if (lq_count !== 3'd2) $display("FAIL rstmid_count2: got %0d want 2", lq_count); else passed++;
        alu_valid = 1'b0; ld_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (lq_count !== 3'd0) $display("FAIL rstmid_count: got %0d want 0", lq_count); else passed++;
        checks++; if (hazard !== 1'b0) $display("FAIL rstmid_hazard: got %b want 0", hazard); else passed++;
        checks++; if (rf_wen !== 1'b0) $display("FAIL rstmid_wen: got %b want 0", rf_wen); else passed++;
        rs2 = 5'd0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst         = $urandom_range(0, 99) == 0;
            alu_valid   = $urandom_range(0, 2) != 0;
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            ld_issue    = $urandom_range(0, 2) == 0;
            ld_issue_rd = 5'($urandom_range(0, 7));
            ld_valid    = $urandom_range(0, 1) != 0;
            ld_rd       = 5'($urandom_range(0, 7));
            ld_data     = $urandom;
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            #1;
            checks++; if (alu_ready !== m_alu_ready()) $display("FAIL rnd_alu_ready c%0d: got %b want %b", c, alu_ready, m_alu_ready()); else passed++;
            checks++; if (ld_ready !== m_ld_ready()) $display("FAIL rnd_ld_ready c%0d: got %b want %b", c, ld_ready, m_ld_ready()); else passed++;
            checks++; if (hazard !== m_hazard()) $display("FAIL rnd_hazard c%0d: got %b want %b", c, hazard, m_hazard()); else passed++;
            tick();
            checks++; if (rf_wen !== m_wen) $display("FAIL rnd_wen c%0d: got %b want %b", c, rf_wen, m_wen); else passed++;
            checks++; if (rf_rd !== m_rd) $display("FAIL rnd_rd c%0d: got %0d want %0d", c, rf_rd, m_rd); else passed++;
            checks++; if (rf_wdata !== m_wd) $display("FAIL rnd_wdata c%0d: got %h want %h", c, rf_wdata, m_wd); else passed++;
            checks++; if (lq_count !== 3'(lq.size())) $display("FAIL rnd_count c%0d: got %0d want %0d", c, lq_count, lq.size()); else passed++;
        end
        rst = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0; ld_issue = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_hazard();
        test_starve();
        test_fifo_full();
        test_x0();
        test_same_edge_and_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1);
    end
endmodule
